sm3_cf_scheduler: RTL and testbench
===================================

SM3_CF_SCHEDULER -- requirements
Module: sm3_cf_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one sm3_CF compression core.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles in RUN before abort.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  in  NREQ  per-requester request level.
REQ-006 SHALL have port iv_in  in  NREQ*256  per-requester chaining value; slice k = bits [256k+255:256k].
REQ-007 SHALL have port blk_in  in  NREQ*512  per-requester padded message block; slice k = bits [512k+511:512k].
REQ-008 SHALL have port done  out  NREQ  one-hot, one-cycle completion pulse.
REQ-009 SHALL have port digest  out  256  result of the last completed job.
REQ-010 SHALL have port err  out  1  one-cycle pulse, coincident with done, on timeout abort.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have ports cf_start out 1, cf_iv out 256, cf_blk out 512, cf_hash in 256, cf_end in 1: the sm3_CF core connection.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE: if any req bit is high, SHALL grant by round-robin starting at index ptr, latch the granted iv/blk slices into cf_iv/cf_blk, assert cf_start, clear the timer, record the grant index and go to RUN, all at one edge.
REQ-015 Round-robin: after each grant, ptr SHALL become (grant+1) mod NREQ.
REQ-016 RUN: cf_start SHALL stay high until cf_end is sampled high. At that edge, cf_start SHALL go low, digest SHALL load cf_hash, and the state SHALL go to DONE.
REQ-017 RUN: the timer SHALL increment each cycle. On reaching TIMEOUT without cf_end, cf_start SHALL drop, digest SHALL be left unchanged, err SHALL be set, and the state SHALL go to DONE.
REQ-018 DONE: done[grant] SHALL be high for exactly this one cycle, with err as set in RUN. The next state SHALL be IDLE, and err SHALL clear.
REQ-019 Latency: req sampled at edge E gives cf_start high after E. A cf_end sampled at edge F gives done high for the cycle after F.
REQ-020 A requester SHALL hold req, iv and blk stable until its done pulse and drop req in the following cycle. Inputs SHALL be sampled only at grant.
REQ-021 req dropped during RUN SHALL NOT abort the job; done SHALL still pulse.
REQ-022 cf_end SHALL be ignored in IDLE and DONE.
REQ-023 cf_iv/cf_blk SHALL stay constant from grant until the next grant.
REQ-024 The DONE cycle SHALL guarantee at least one cycle with cf_start low between consecutive jobs.
REQ-025 Simultaneous requests: exactly one grant per job, with no requester starved beyond NREQ-1 intervening jobs.

Reset
REQ-026 Reset low SHALL asynchronously force state IDLE, ptr=0, timer=0, grant=0, cf_start=0, done=0, err=0, digest=0, cf_iv=0, cf_blk=0 and busy=0. This SHALL also apply during RUN, with no done issued.
REQ-027 After reset release, the first grant SHALL favour index 0.

Structure
REQ-028 Shared package sm3_pkg SHALL hold the state encoding, SM3_IV constant (7380166f...b0fb0e4e), and width constants 256/512.
REQ-029 Round-robin selection SHALL be one combinational sub-module rr_arbiter (req, ptr -> one-hot grant, valid); the FSM and registers stay in sm3_cf_scheduler.

Verification
REQ-030 Single job: req[2]=1, iv=SM3_IV, blk=padded "abc" -> done[2] pulses once, digest=66c7f0f4...8f4ba8e0, busy low the next cycle.
REQ-031 Contention: req=4'b1111 held, each dropped after its done -> grant order 0,1,2,3, each with its own correct digest, and cf_start low at least 1 cycle between jobs.
REQ-032 Fairness: req[0] held continuously re-requesting with req[3]=1 -> grants alternate 0,3,0,3.
REQ-033 Timeout: core model never raises cf_end -> after 255 RUN cycles, done[k]=1, err=1, digest unchanged, cf_start=0.
REQ-034 Reset mid-RUN: reset asserted 10 cycles after grant -> all outputs 0 immediately, no done; next request is granted normally with ptr=0.
REQ-035 Stray cf_end in IDLE, and req dropped mid-RUN -> no state change in IDLE; the dropped-req job still completes with a done pulse.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 compression scheduler: widths, the
// standard SM3 initial chaining value and the scheduler state encoding.
package sm3_pkg;

  localparam int HASH_W = 256;
  localparam int BLK_W  = 512;

  localparam logic [HASH_W-1:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sm3_cf_scheduler_if.sv
// Connection to the shared sm3_CF compression core. The scheduler drives
// start/iv/blk and the core returns hash/end.
interface sm3_cf_scheduler_if;
  import sm3_pkg::*;

  logic              cf_start;
  logic [HASH_W-1:0] cf_iv;
  logic [BLK_W-1:0]  cf_blk;
  logic [HASH_W-1:0] cf_hash;
  logic              cf_end;

  modport master (output cf_start, output cf_iv, output cf_blk,
                  input  cf_hash,  input  cf_end);

  modport slave  (input  cf_start, input  cf_iv, input  cf_blk,
                  output cf_hash,  output cf_end);

endinterface

// File: rtl/sm3_cf_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or
// after ptr (wrapping) wins; grant is one-hot, valid flags any winner.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  logic [PW:0] idx;

  // Walk the requesters starting at ptr and keep the first one found.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!valid && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        valid              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sm3_cf_scheduler.sv
// Shares one sm3_CF compression core among NREQ requesters. A request is
// granted round-robin, its chaining value and block are latched onto the
// core, and completion (or a timeout abort) is reported by a one-cycle
// done pulse on the granted requester.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | core free; grant the next requester when any req is high
// RUN     | cf_start held high, waiting for cf_end or the timeout
// DONE    | one-cycle done[grant] (with err on abort); cf_start is low
module sm3_cf_scheduler
  import sm3_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*HASH_W-1:0] iv_in,
  input  logic [NREQ*BLK_W-1:0]  blk_in,
  output logic [NREQ-1:0]        done,
  output logic [HASH_W-1:0]      digest,
  output logic                   err,
  output logic                   busy,
  sm3_cf_scheduler_if.master     cf
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic [TW-1:0]     timer;
  logic              err_q;
  logic [HASH_W-1:0] digest_q;
  logic [HASH_W-1:0] iv_q;
  logic [BLK_W-1:0]  blk_q;

  logic [NREQ-1:0]   arb_gnt;
  logic              arb_valid;
  logic [PW-1:0]     arb_idx;
  logic [HASH_W-1:0] sel_iv;
  logic [BLK_W-1:0]  sel_blk;
  logic              tmo;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_gnt),
    .valid (arb_valid)
  );

  // Turn the one-hot grant into an index and pick that requester's slices.
  always_comb begin
    arb_idx = '0;
    sel_iv  = '0;
    sel_blk = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        arb_idx = PW'(k);
        sel_iv  = iv_in[k*HASH_W +: HASH_W];
        sel_blk = blk_in[k*BLK_W +: BLK_W];
      end
    end
  end

  // Last permitted RUN cycle: the job has been running TIMEOUT cycles.
  assign tmo = (timer == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; cf_end only matters while a job is running.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (arb_valid)        state_nxt = ST_RUN;
      ST_RUN:  if (cf.cf_end || tmo) state_nxt = ST_DONE;
      ST_DONE:                       state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, operand latch, timeout timer and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      grant_idx <= '0;
      timer     <= '0;
      err_q     <= 1'b0;
      digest_q  <= '0;
      iv_q      <= '0;
      blk_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            ptr       <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
            grant_idx <= arb_idx;
            timer     <= '0;
            iv_q      <= sel_iv;
            blk_q     <= sel_blk;
          end
        end
        ST_RUN: begin
          if (cf.cf_end)  digest_q <= cf.cf_hash;
          else if (tmo)   err_q    <= 1'b1;
          else            timer    <= timer + TW'(1);
        end
        ST_DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; cf_start is high for the whole RUN phase.
  always_comb begin
    done        = '0;
    err         = 1'b0;
    busy        = (state != ST_IDLE);
    cf.cf_start = (state == ST_RUN);
    if (state == ST_DONE) begin
      done[grant_idx] = 1'b1;
      err             = err_q;
    end
  end

  assign cf.cf_iv  = iv_q;
  assign cf.cf_blk = blk_q;
  assign digest    = digest_q;

endmodule

// File: tb/tb_sm3_cf_scheduler.sv
// Bench for sm3_cf_scheduler: a behavioural sm3_CF core answers each job
// with the real compression result after a random delay, and a monitor
// predicts grants, digests and error flags from round-robin rules.
module tb_sm3_cf_scheduler;
  import sm3_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 255;
  localparam logic [511:0] ABC_BLK    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*HASH_W-1:0] iv_in = '0;
  logic [NREQ*BLK_W-1:0]  blk_in = '0;
  logic [NREQ-1:0]        done;
  logic [HASH_W-1:0]      digest;
  logic                   err;
  logic                   busy;

  sm3_cf_scheduler_if cf_if ();

  sm3_cf_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .iv_in  (iv_in),
    .blk_in (blk_in),
    .done   (done),
    .digest (digest),
    .err    (err),
    .busy   (busy),
    .cf     (cf_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int              ptr_m, exp_idx, run_cnt, gap, done_cnt;
  logic [255:0]    exp_hash, exp_iv, exp_digest;
  logic [511:0]    exp_blk;
  bit              prev_start;
  int              grant_log[$];
  int              starve[NREQ];
  bit              never_end = 1'b0;
  int              fixed_lat = -1;
  int              stray_req = 0;
  bit              rand_mode = 1'b0;
  logic [NREQ-1:0] auto_drop = '0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // Reference SM3 compression function CF(V, B).
  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [0:67];
    logic [31:0] w1 [0:63];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) w1[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      ss1 = rotl(rotl(a, 12) + e + rotl(tj, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      tt1 = ff + d + ss2 + w1[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rotl(bb, 9); bb = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic int glog(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return -1;
  endfunction

  // Behavioural sm3_CF core: answers a started job after a delay.
  initial begin
    logic [255:0] civ;
    logic [511:0] cblk;
    int           lat;
    bit           cbusy;
    int           stray_done;
    cf_if.cf_end  = 1'b0;
    cf_if.cf_hash = '0;
    cbusy = 1'b0; stray_done = 0; lat = 0; civ = '0; cblk = '0;
    forever begin
      @(negedge clk);
      cf_if.cf_end = 1'b0;
      if (stray_done != stray_req) begin
        stray_done    = stray_req;
        cf_if.cf_end  = 1'b1;
        cf_if.cf_hash = rand256();
      end else if (cbusy) begin
        if (!cf_if.cf_start || !reset) cbusy = 1'b0;
        else if (lat == 0) begin
          cf_if.cf_end  = 1'b1;
          cf_if.cf_hash = sm3_cf(civ, cblk);
          cbusy         = 1'b0;
        end else lat--;
      end else if (cf_if.cf_start && reset && !never_end) begin
        cbusy = 1'b1;
        civ   = cf_if.cf_iv;
        cblk  = cf_if.cf_blk;
        lat   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
      end
    end
  end

  // Monitor: round-robin prediction at each job start, result checks at each job end.
  initial begin
    int              idx, k, maxs;
    logic [NREQ-1:0] oh;
    ptr_m = 0; gap = 1; prev_start = 1'b0; done_cnt = 0; run_cnt = 0;
    exp_idx = 0; exp_digest = '0; exp_hash = '0; exp_iv = '0; exp_blk = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        prev_start = 1'b0; ptr_m = 0; exp_digest = '0; gap = 1;
        for (int i = 0; i < NREQ; i++) starve[i] = 0;
      end else begin
        if (cf_if.cf_start && !prev_start) begin
          chk("start_gap", (gap >= 1), 1);
          idx = -1;
          for (int i = 0; i < NREQ; i++) begin
            k = (ptr_m + i) % NREQ;
            if (idx < 0 && req[k]) idx = k;
          end
          chk("req_at_grant", (idx >= 0), 1);
          if (idx < 0) idx = 0;
          maxs = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (i == idx || !req[i]) starve[i] = 0;
            else starve[i]++;
            if (starve[i] > maxs) maxs = starve[i];
          end
          chk("starvation_bound", (maxs <= NREQ - 1), 1);
          exp_idx  = idx;
          ptr_m    = (idx + 1) % NREQ;
          exp_iv   = iv_in[idx*HASH_W +: HASH_W];
          exp_blk  = blk_in[idx*BLK_W +: BLK_W];
          exp_hash = sm3_cf(exp_iv, exp_blk);
          chk("cf_iv_at_grant", cf_if.cf_iv, exp_iv);
          chk("cf_blk_at_grant", cf_if.cf_blk, exp_blk);
          grant_log.push_back(idx);
          run_cnt = 0;
        end
        if (cf_if.cf_start) begin run_cnt++; gap = 0; end
        else gap++;
        if (!cf_if.cf_start && prev_start) begin
          oh = '0; oh[exp_idx] = 1'b1;
          chk("done_onehot", done, oh);
          chk("err_flag", err, never_end);
          chk("busy_in_done", busy, 1);
          chk("cf_iv_stable", cf_if.cf_iv, exp_iv);
          chk("cf_blk_stable", cf_if.cf_blk, exp_blk);
          if (never_end) chk("timeout_run_cycles", run_cnt, TIMEOUT);
          else begin
            chk("cf_end_to_done", cf_if.cf_end, 1);
            exp_digest = exp_hash;
          end
          chk("digest", digest, exp_digest);
          done_cnt++;
        end else if (done != '0) chk("unexpected_done", done, 0);
        prev_start = cf_if.cf_start;
      end
    end
  end

  task automatic set_slice(input int k, input logic [255:0] v, input logic [511:0] b);
    iv_in[k*HASH_W +: HASH_W] = v;
    blk_in[k*BLK_W +: BLK_W]  = b;
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NREQ; k++)
      if (done[k] && auto_drop[k]) req[k] = 1'b0;
    if (rand_mode)
      for (int k = 0; k < NREQ; k++)
        if (!req[k] && !done[k] && $urandom_range(0, 3) == 0) begin
          set_slice(k, rand256(), rand512());
          auto_drop[k] = 1'b1;
          req[k]       = 1'b1;
        end
  endtask

  task automatic wait_jobs(input int n, input int budget, input string tag);
    int target, cyc;
    target = done_cnt + n;
    cyc    = 0;
    while (done_cnt < target && cyc < budget) begin tick(); cyc++; end
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (!cf_if.cf_start && cyc < budget) begin tick(); cyc++; end
    chk(tag, cf_if.cf_start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int base, snap, cyc;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_digest", digest, 0);
    chk("rst_cf_start", cf_if.cf_start, 0);
    chk("rst_cf_iv", cf_if.cf_iv, 0);
    chk("rst_cf_blk", cf_if.cf_blk, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single "abc" job on requester 2.
    set_slice(2, SM3_IV, ABC_BLK);
    auto_drop[2] = 1'b1;
    req[2]       = 1'b1;
    base = grant_log.size();
    wait_jobs(1, 50, "wait_abc");
    chk("abc_grant", glog(base), 2);
    chk("abc_done", done, 4'b0100);
    chk("abc_digest", digest, ABC_DIGEST);
    tick();
    chk("abc_busy_after", busy, 0);

    // All four requesting at once.
    do_reset();
    for (int k = 0; k < NREQ; k++) set_slice(k, rand256(), rand512());
    auto_drop = '1;
    req       = '1;
    base = grant_log.size();
    wait_jobs(4, 200, "wait_contention");
    for (int i = 0; i < 4; i++) chk("contention_order", glog(base + i), i);

    // Requester 0 keeps re-requesting alongside requester 3.
    do_reset();
    for (int k = 0; k < NREQ; k++) set_slice(k, rand256(), rand512());
    auto_drop = '0;
    req       = 4'b1001;
    base = grant_log.size();
    wait_jobs(4, 200, "wait_fairness");
    req = '0;
    chk("fair_g0", glog(base), 0);
    chk("fair_g1", glog(base + 1), 3);
    chk("fair_g2", glog(base + 2), 0);
    chk("fair_g3", glog(base + 3), 3);

    // Core never answers: abort after TIMEOUT RUN cycles.
    repeat (2) tick();
    never_end = 1'b1;
    set_slice(1, rand256(), rand512());
    auto_drop[1] = 1'b1;
    req[1]       = 1'b1;
    wait_jobs(1, TIMEOUT + 50, "wait_timeout");
    chk("timeout_err", err, 1);
    chk("timeout_cf_start", cf_if.cf_start, 0);
    chk("timeout_digest", digest, exp_digest);
    tick();
    never_end = 1'b0;
    chk("timeout_err_clear", err, 0);

    // Reset 10 cycles into a job.
    set_slice(2, rand256(), rand512());
    auto_drop[2] = 1'b1;
    req[2]       = 1'b1;
    wait_start(20, "wait_start_mid_reset");
    repeat (10) tick();
    snap = done_cnt;
    #2 reset = 1'b0;
    #1;
    chk("midrst_cf_start", cf_if.cf_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_digest", digest, 0);
    chk("midrst_cf_iv", cf_if.cf_iv, 0);
    chk("midrst_cf_blk", cf_if.cf_blk, 0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("midrst_no_done", done_cnt, snap);
    set_slice(1, rand256(), rand512());
    set_slice(3, rand256(), rand512());
    auto_drop = '1;
    req       = 4'b1010;
    base = grant_log.size();
    wait_jobs(2, 100, "wait_after_reset");
    chk("after_reset_g0", glog(base), 1);
    chk("after_reset_g1", glog(base + 1), 3);

    // Stray cf_end while idle.
    repeat (3) tick();
    snap = done_cnt;
    stray_req++;
    repeat (4) tick();
    chk("stray_busy", busy, 0);
    chk("stray_cf_start", cf_if.cf_start, 0);
    chk("stray_digest", digest, exp_digest);
    chk("stray_no_done", done_cnt, snap);

    // Requester drops req while its job runs.
    fixed_lat = 20;
    set_slice(1, rand256(), rand512());
    auto_drop[1] = 1'b1;
    req[1]       = 1'b1;
    base = grant_log.size();
    wait_start(20, "wait_start_drop");
    repeat (3) tick();
    req[1] = 1'b0;
    wait_jobs(1, 60, "wait_dropped_job");
    fixed_lat = -1;
    chk("dropped_grant", glog(base), 1);

    // Random request traffic.
    rand_mode = 1'b1;
    wait_jobs(40, 3000, "wait_random");
    rand_mode = 1'b0;
    cyc = 0;
    while ((req != '0 || busy) && cyc < 300) begin tick(); cyc++; end
    chk("random_drain", {req != '0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
